wb_arbiter: RTL and testbench

Write-back arbiter between the Memory stage and the register file. Each cycle it accepts up to four results from the Memory stage (ALU0, ALU1, Multiply, Load) and funnels them through an in-order queue onto two register-file write ports. It asserts `stall` to the pipeline whenever the queue cannot absorb a worst-case cycle of four results.

---
 rtl/wb_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_wb_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// wb_arbiter: write-back arbiter between the Memory stage and the register file.
// Up to four results per cycle (ALU0, ALU1, Multiply, Load) are packed in
// program order into an in-order queue and drained onto two write ports.
// Optional macro WB_FWD_EN adds a combinational forwarding lookup
// (fwd_tag / fwd_hit / fwd_data) over the queue and the write-port registers.
module wb_arbiter #(
    parameter int unsigned DEPTH = 8
) (
    input  logic        ref_clk,
    input  logic        rst,
    input  logic [15:0] A0_in,
    input  logic [4:0]  A0_Rd_tag_in,
    input  logic [15:0] A1_in,
    input  logic [4:0]  A1_Rd_tag_in,
    input  logic [15:0] M_in,
    input  logic [4:0]  M_Rd_tag_in,
    input  logic [7:0]  LS_in,
    input  logic [4:0]  LS_Rd_tag_in,
`ifdef WB_FWD_EN
    input  logic [4:0]  fwd_tag,
    output logic        fwd_hit,
    output logic [15:0] fwd_data,
`endif
    output logic        wb0_en,
    output logic [4:0]  wb0_tag,
    output logic [15:0] wb0_data,
    output logic        wb1_en,
    output logic [4:0]  wb1_tag,
    output logic [15:0] wb1_data,
    output logic        stall
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [4:0]    mem_tag  [DEPTH];
    logic [15:0]   mem_data [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic [4:0]    ch_tag   [4];
    logic [15:0]   ch_data  [4];
    logic [4:0]    inc_tag  [4];
    logic [15:0]   inc_data [4];
    logic [2:0]    inc_n;

    logic [CW-1:0] avail;
    logic [PW-1:0] rd1;
    logic          nxt_en0;
    logic          nxt_en1;
    logic [1:0]    deq_n;
    logic [4:0]    nxt_tag0;
    logic [4:0]    nxt_tag1;
    logic [15:0]   nxt_data0;
    logic [15:0]   nxt_data1;

    // Stall whenever a worst-case cycle of four results might not fit.
    always_comb begin
        stall = (count > CW'(DEPTH - 4));
    end

    // Pack the valid channels contiguously in program order A0, A1, M, LS.
    always_comb begin
        ch_tag[0]  = A0_Rd_tag_in;
        ch_data[0] = A0_in;
        ch_tag[1]  = A1_Rd_tag_in;
        ch_data[1] = A1_in;
        ch_tag[2]  = M_Rd_tag_in;
        ch_data[2] = M_in;
        ch_tag[3]  = LS_Rd_tag_in;
        ch_data[3] = {8'h00, LS_in};
        inc_n = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            inc_tag[i]  = '0;
            inc_data[i] = '0;
        end
        if (!stall) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (ch_tag[i] != 5'd0) begin
                    inc_tag[inc_n[1:0]]  = ch_tag[i];
                    inc_data[inc_n[1:0]] = ch_data[i];
                    inc_n = inc_n + 3'd1;
                end
            end
        end
    end

    // Select the two oldest entries of (queue ++ incoming); incoming results
    // bypass the storage so an empty queue still gives one-edge latency.
    always_comb begin
        avail     = count + CW'(inc_n);
        rd1       = rd_ptr + PW'(1);
        nxt_en0   = (avail != '0);
        nxt_en1   = (avail > CW'(1));
        deq_n     = nxt_en1 ? 2'd2 : {1'b0, nxt_en0};
        nxt_tag0  = '0;
        nxt_data0 = '0;
        nxt_tag1  = '0;
        nxt_data1 = '0;
        if (nxt_en0) begin
            if (count != '0) begin
                nxt_tag0  = mem_tag[rd_ptr];
                nxt_data0 = mem_data[rd_ptr];
            end else begin
                nxt_tag0  = inc_tag[0];
                nxt_data0 = inc_data[0];
            end
        end
        if (nxt_en1) begin
            if (count > CW'(1)) begin
                nxt_tag1  = mem_tag[rd1];
                nxt_data1 = mem_data[rd1];
            end else if (count == CW'(1)) begin
                nxt_tag1  = inc_tag[0];
                nxt_data1 = inc_data[0];
            end else begin
                nxt_tag1  = inc_tag[1];
                nxt_data1 = inc_data[1];
            end
        end
    end

    // Queue storage; stale slots are harmless because pointers/count gate use.
    always_ff @(posedge ref_clk) begin
        for (int unsigned i = 0; i < 4; i++) begin
            if (3'(i) < inc_n) begin
                mem_tag[wr_ptr + PW'(i)]  <= inc_tag[i];
                mem_data[wr_ptr + PW'(i)] <= inc_data[i];
            end
        end
    end

    // Pointers, occupancy and registered write-port outputs.
    always_ff @(posedge ref_clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            wb0_en   <= 1'b0;
            wb0_tag  <= '0;
            wb0_data <= '0;
            wb1_en   <= 1'b0;
            wb1_tag  <= '0;
            wb1_data <= '0;
        end else begin
            wr_ptr   <= wr_ptr + PW'(inc_n);
            rd_ptr   <= rd_ptr + PW'(deq_n);
            count    <= count + CW'(inc_n) - CW'(deq_n);
            wb0_en   <= nxt_en0;
            wb0_tag  <= nxt_tag0;
            wb0_data <= nxt_data0;
            wb1_en   <= nxt_en1;
            wb1_tag  <= nxt_tag1;
            wb1_data <= nxt_data1;
        end
    end

`ifdef WB_FWD_EN
    // Forward lookup, scanned oldest to youngest so the youngest match wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        if (fwd_tag != 5'd0) begin
            if (wb0_en && (wb0_tag == fwd_tag)) begin
                fwd_hit  = 1'b1;
                fwd_data = wb0_data;
            end
            if (wb1_en && (wb1_tag == fwd_tag)) begin
                fwd_hit  = 1'b1;
                fwd_data = wb1_data;
            end
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if ((CW'(i) < count) && (mem_tag[rd_ptr + PW'(i)] == fwd_tag)) begin
                    fwd_hit  = 1'b1;
                    fwd_data = mem_data[rd_ptr + PW'(i)];
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: randomized and directed bench for wb_arbiter against a
// queue-based reference model (optionally with WB_FWD_EN forwarding).
module tb_wb_arbiter;

    localparam int DEPTH = 8;

    logic        ref_clk;
    logic        rst;
    logic [15:0] A0_in;
    logic [4:0]  A0_Rd_tag_in;
    logic [15:0] A1_in;
    logic [4:0]  A1_Rd_tag_in;
    logic [15:0] M_in;
    logic [4:0]  M_Rd_tag_in;
    logic [7:0]  LS_in;
    logic [4:0]  LS_Rd_tag_in;
    logic        wb0_en;
    logic [4:0]  wb0_tag;
    logic [15:0] wb0_data;
    logic        wb1_en;
    logic [4:0]  wb1_tag;
    logic [15:0] wb1_data;
    logic        stall;
`ifdef WB_FWD_EN
    logic [4:0]  fwd_tag;
    logic        fwd_hit;
    logic [15:0] fwd_data;
`endif

    wb_arbiter #(.DEPTH(DEPTH)) dut (
        .ref_clk      (ref_clk),
        .rst          (rst),
        .A0_in        (A0_in),
        .A0_Rd_tag_in (A0_Rd_tag_in),
        .A1_in        (A1_in),
        .A1_Rd_tag_in (A1_Rd_tag_in),
        .M_in         (M_in),
        .M_Rd_tag_in  (M_Rd_tag_in),
        .LS_in        (LS_in),
        .LS_Rd_tag_in (LS_Rd_tag_in),
`ifdef WB_FWD_EN
        .fwd_tag      (fwd_tag),
        .fwd_hit      (fwd_hit),
        .fwd_data     (fwd_data),
`endif
        .wb0_en       (wb0_en),
        .wb0_tag      (wb0_tag),
        .wb0_data     (wb0_data),
        .wb1_en       (wb1_en),
        .wb1_tag      (wb1_tag),
        .wb1_data     (wb1_data),
        .stall        (stall)
    );

    initial begin
        ref_clk = 1'b0;
        forever #5 ref_clk = ~ref_clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: results waiting for a write port, oldest first.
    logic [4:0]  qt[$];
    logic [15:0] qd[$];
    logic        exp_en0, exp_en1;
    logic [4:0]  exp_tag0, exp_tag1;
    logic [15:0] exp_data0, exp_data1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        qt.delete();
        qd.delete();
        exp_en0 = 1'b0; exp_tag0 = '0; exp_data0 = '0;
        exp_en1 = 1'b0; exp_tag1 = '0; exp_data1 = '0;
    endtask

`ifdef WB_FWD_EN
    task automatic check_fwd(input logic [4:0] ft);
        logic        h;
        logic [15:0] d;
        h = 1'b0;
        d = '0;
        fwd_tag = ft;
        #1;
        if (ft != 5'd0) begin
            // Youngest first: newest queued entry, then wb1, then wb0.
            for (int i = qt.size() - 1; i >= 0 && !h; i--) begin
                if (qt[i] == ft) begin h = 1'b1; d = qd[i]; end
            end
            if (!h && exp_en1 && exp_tag1 == ft) begin h = 1'b1; d = exp_data1; end
            if (!h && exp_en0 && exp_tag0 == ft) begin h = 1'b1; d = exp_data0; end
        end
        check("fwd_hit", {31'd0, fwd_hit}, {31'd0, h});
        check("fwd_data", {16'd0, fwd_data}, {16'd0, d});
    endtask
`endif

    task automatic compare_all();
        check("wb0_en", {31'd0, wb0_en}, {31'd0, exp_en0});
        check("wb0_tag", {27'd0, wb0_tag}, {27'd0, exp_tag0});
        check("wb0_data", {16'd0, wb0_data}, {16'd0, exp_data0});
        check("wb1_en", {31'd0, wb1_en}, {31'd0, exp_en1});
        check("wb1_tag", {27'd0, wb1_tag}, {27'd0, exp_tag1});
        check("wb1_data", {16'd0, wb1_data}, {16'd0, exp_data1});
        check("stall", {31'd0, stall}, {31'd0, (qt.size() > DEPTH - 4)});
`ifdef WB_FWD_EN
        check_fwd(5'($urandom_range(0, 8)));
`endif
    endtask

    // One clock: drive inputs, advance the model, then compare after the edge.
    task automatic step(input logic [4:0] t0, input logic [15:0] d0,
                        input logic [4:0] t1, input logic [15:0] d1,
                        input logic [4:0] tm, input logic [15:0] dm,
                        input logic [4:0] tl, input logic [7:0] dl);
        A0_Rd_tag_in = t0; A0_in = d0;
        A1_Rd_tag_in = t1; A1_in = d1;
        M_Rd_tag_in  = tm; M_in  = dm;
        LS_Rd_tag_in = tl; LS_in = dl;
        if (!(qt.size() > DEPTH - 4)) begin
            if (t0 != 5'd0) begin qt.push_back(t0); qd.push_back(d0); end
            if (t1 != 5'd0) begin qt.push_back(t1); qd.push_back(d1); end
            if (tm != 5'd0) begin qt.push_back(tm); qd.push_back(dm); end
            if (tl != 5'd0) begin qt.push_back(tl); qd.push_back({8'h00, dl}); end
        end
        exp_en0 = 1'b0; exp_tag0 = '0; exp_data0 = '0;
        exp_en1 = 1'b0; exp_tag1 = '0; exp_data1 = '0;
        if (qt.size() > 0) begin
            exp_en0 = 1'b1; exp_tag0 = qt.pop_front(); exp_data0 = qd.pop_front();
        end
        if (qt.size() > 0) begin
            exp_en1 = 1'b1; exp_tag1 = qt.pop_front(); exp_data1 = qd.pop_front();
        end
        @(posedge ref_clk);
        #1;
        compare_all();
    endtask

    task automatic idle();
        step(5'd0, 16'h0, 5'd0, 16'h0, 5'd0, 16'h0, 5'd0, 8'h0);
    endtask

    task automatic four(input logic [4:0] base);
        step(base, {11'd0, base}, base + 5'd1, 16'h100,
             base + 5'd2, 16'h200, base + 5'd3, {3'd0, base});
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic pulse_reset();
        #3;
        rst = 1'b1;
        #1;
        check("rst_wb0_en", {31'd0, wb0_en}, 32'd0);
        check("rst_wb0_data", {16'd0, wb0_data}, 32'd0);
        check("rst_wb1_en", {31'd0, wb1_en}, 32'd0);
        check("rst_wb1_tag", {27'd0, wb1_tag}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
`ifdef WB_FWD_EN
        check("rst_fwd_hit", {31'd0, fwd_hit}, 32'd0);
        check("rst_fwd_data", {16'd0, fwd_data}, 32'd0);
`endif
        model_clear();
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        A0_in = '0; A0_Rd_tag_in = '0; A1_in = '0; A1_Rd_tag_in = '0;
        M_in = '0; M_Rd_tag_in = '0; LS_in = '0; LS_Rd_tag_in = '0;
`ifdef WB_FWD_EN
        fwd_tag = '0;
`endif
        model_clear();
        #12;
        check("reset_wb0_en", {31'd0, wb0_en}, 32'd0);
        check("reset_wb1_en", {31'd0, wb1_en}, 32'd0);
        check("reset_stall", {31'd0, stall}, 32'd0);
        rst = 1'b0;

        // Single write: one-edge latency, only wb0 fires.
        step(5'd3, 16'h1234, 5'd0, 16'h0, 5'd0, 16'h0, 5'd0, 8'h0);
        check("single_wb0_en", {31'd0, wb0_en}, 32'd1);
        check("single_wb0_tag", {27'd0, wb0_tag}, 32'd3);
        check("single_wb0_data", {16'd0, wb0_data}, 32'h1234);
        check("single_wb1_en", {31'd0, wb1_en}, 32'd0);
        idle();
        check("single_after_en0", {31'd0, wb0_en}, 32'd0);
        check("single_after_en1", {31'd0, wb1_en}, 32'd0);

        // Four-channel order with zero-extended load data.
        step(5'd1, 16'hA, 5'd2, 16'hB, 5'd3, 16'hC, 5'd4, 8'hFF);
        check("order_c1_wb0", {11'd0, wb0_tag, wb0_data}, {11'd0, 5'd1, 16'hA});
        check("order_c1_wb1", {11'd0, wb1_tag, wb1_data}, {11'd0, 5'd2, 16'hB});
        idle();
        check("order_c2_wb0", {11'd0, wb0_tag, wb0_data}, {11'd0, 5'd3, 16'hC});
        check("order_c2_wb1", {11'd0, wb1_tag, wb1_data}, {11'd0, 5'd4, 16'h00FF});
        idle();

        // Same tag twice keeps program order.
        step(5'd5, 16'h1, 5'd0, 16'h0, 5'd5, 16'h2, 5'd0, 8'h0);
        check("same_wb0_data", {16'd0, wb0_data}, 32'h1);
        check("same_wb1_data", {16'd0, wb1_data}, 32'h2);
        idle();

        // Stall at capacity: 4 valid inputs every cycle.
        four(5'd1);
        four(5'd5);
        four(5'd9);
        check("cap_stall_3rd", {31'd0, stall}, 32'd1);
        four(5'd13);
        check("cap_stall_release", {31'd0, stall}, 32'd0);
        four(5'd17);
        for (int i = 0; i < 6; i++) idle();
        check("cap_drained", {31'd0, wb0_en}, 32'd0);

        // Reset mid-drain with 6 entries queued.
        four(5'd1);
        four(5'd5);
        four(5'd9);
        pulse_reset();
        idle();
        check("post_rst_en0", {31'd0, wb0_en}, 32'd0);
        idle();

`ifdef WB_FWD_EN
        // Forwarding: youngest match wins, tag 0 never hits.
        step(5'd7, 16'h11, 5'd7, 16'h22, 5'd0, 16'h0, 5'd0, 8'h0);
        fwd_tag = 5'd7;
        #1;
        check("fwd7_hit", {31'd0, fwd_hit}, 32'd1);
        check("fwd7_data", {16'd0, fwd_data}, 32'h22);
        fwd_tag = 5'd0;
        #1;
        check("fwd0_hit", {31'd0, fwd_hit}, 32'd0);
        idle();
`endif

        // Randomized traffic with occasional asynchronous resets.
        for (int n = 0; n < 400; n++) begin
            logic [4:0] t[4];
            for (int c = 0; c < 4; c++) begin
                t[c] = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(1, 8));
            end
            step(t[0], 16'($urandom), t[1], 16'($urandom),
                 t[2], 16'($urandom), t[3], 8'($urandom));
            if ($urandom_range(0, 99) == 0) pulse_reset();
        end
        for (int i = 0; i < 6; i++) idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
